// File: rtl/rst_seq_sys.sv
// Reset sequencer: synchronises the board button and clock-lock inputs, debounces the
// button, then releases the peripheral reset followed later by the core reset.
module rst_seq_sys #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGGER_CYCLES  = 8
) (
  input  logic       clk_sys,
  input  logic       rst_sys,
  input  logic       ext_rst_ni,
  input  logic       lock_i,
  input  logic       sw_rst_req_i,
  output logic       rst_periph_no,
  output logic       rst_core_no,
  output logic [1:0] rst_cause_o
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SEQ_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEQ_W-1:0] HOLD_LAST    = SEQ_W'(HOLD_CYCLES - 1);
  localparam logic [SEQ_W-1:0] STAGGER_LAST = SEQ_W'(STAGGER_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR    = 2'b00;
  localparam logic [1:0] CAUSE_BUTTON = 2'b01;
  localparam logic [1:0] CAUSE_LOCK   = 2'b10;
  localparam logic [1:0] CAUSE_SW     = 2'b11;

  typedef enum logic [1:0] {
    RESET,
    HOLD,
    PERIPH_UP,
    RUN
  } state_t;

  logic [SYNC_STAGES-1:0] btn_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   btn_s;
  logic                   lock_s;
  logic                   btn_deb;
  logic [DEB_W-1:0]       deb_cnt;
  logic [SEQ_W-1:0]       seq_cnt;
  state_t                 state;
  logic                   req;
  logic [1:0]             req_cause;

  // Button sync stores the inverted level so its reset value reads as "pressed".
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      btn_sync  <= '1;
      lock_sync <= '0;
    end else begin
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], ~ext_rst_ni};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], lock_i};
    end
  end

  assign btn_s  = btn_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      btn_deb <= 1'b1;
      deb_cnt <= '0;
    end else if (btn_s == btn_deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      btn_deb <= btn_s;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign req = ~lock_s | btn_deb | sw_rst_req_i;

  always_comb begin
    req_cause = CAUSE_SW;
    if (~lock_s) begin
      req_cause = CAUSE_LOCK;
    end else if (btn_deb) begin
      req_cause = CAUSE_BUTTON;
    end
  end

  // Requests win over sequence advancement; the cause is latched only on entry to RESET.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state         <= RESET;
      seq_cnt       <= '0;
      rst_periph_no <= 1'b0;
      rst_core_no   <= 1'b0;
      rst_cause_o   <= CAUSE_POR;
    end else if (state == RESET) begin
      rst_periph_no <= 1'b0;
      rst_core_no   <= 1'b0;
      seq_cnt       <= '0;
      if (!req) begin
        state <= HOLD;
      end
    end else if (req) begin
      state         <= RESET;
      seq_cnt       <= '0;
      rst_periph_no <= 1'b0;
      rst_core_no   <= 1'b0;
      rst_cause_o   <= req_cause;
    end else begin
      case (state)
        HOLD: begin
          if (seq_cnt == HOLD_LAST) begin
            state         <= PERIPH_UP;
            rst_periph_no <= 1'b1;
            seq_cnt       <= '0;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end
        PERIPH_UP: begin
          if (seq_cnt == STAGGER_LAST) begin
            state       <= RUN;
            rst_core_no <= 1'b1;
            seq_cnt     <= '0;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end
        default: begin
          seq_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_sys.sv
// Directed bench for rst_seq_sys: a table of timed steps plus hand-written
// sequences for power-on release and asynchronous reset mid-sequence.
module tb_rst_seq_sys;

  logic       clk_sys;
  logic       rst_sys;
  logic       ext_rst_ni;
  logic       lock_i;
  logic       sw_rst_req_i;
  logic       rst_periph_no;
  logic       rst_core_no;
  logic [1:0] rst_cause_o;

  int checks;
  int failures;

  typedef struct {
    string      name;
    int         cycles;
    logic       ext;
    logic       lock;
    logic       sw;
    logic       exp_periph;
    logic       exp_core;
    logic [1:0] exp_cause;
  } step_t;

  step_t steps[$];

  rst_seq_sys #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (16),
    .STAGGER_CYCLES (8)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_sys      (rst_sys),
    .ext_rst_ni   (ext_rst_ni),
    .lock_i       (lock_i),
    .sw_rst_req_i (sw_rst_req_i),
    .rst_periph_no(rst_periph_no),
    .rst_core_no  (rst_core_no),
    .rst_cause_o  (rst_cause_o)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Core reset must never be released while the peripheral reset is still held.
  always @(negedge clk_sys) begin
    checks++;
    if (rst_core_no && !rst_periph_no) begin
      failures++;
      $display("[TB] FAIL core_before_periph at %0t: core=%b periph=%b", $time, rst_core_no, rst_periph_no);
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic exp_periph, input logic exp_core,
                             input logic [1:0] exp_cause);
    checks++;
    if (rst_periph_no !== exp_periph) begin
      failures++;
      $display("[TB] FAIL %s periph: got %b expected %b", name, rst_periph_no, exp_periph);
    end
    checks++;
    if (rst_core_no !== exp_core) begin
      failures++;
      $display("[TB] FAIL %s core: got %b expected %b", name, rst_core_no, exp_core);
    end
    checks++;
    if (rst_cause_o !== exp_cause) begin
      failures++;
      $display("[TB] FAIL %s cause: got %b expected %b", name, rst_cause_o, exp_cause);
    end
  endtask

  // Software request is only ever a single-cycle pulse at the start of a step.
  task automatic applyStimulus(input logic ext, input logic lock, input logic sw, input int cycles);
    ext_rst_ni   = ext;
    lock_i       = lock;
    sw_rst_req_i = sw;
    for (int i = 0; i < cycles; i++) begin
      tick();
      sw_rst_req_i = 1'b0;
    end
  endtask

  // After rst_sys falls: periph rises at edge 23, core at edge 31.
  task automatic powerOnSequence(input string tag);
    rst_sys = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      checkOutput($sformatf("%s_edge%0d", tag, k), (k >= 23), (k >= 31), 2'b00);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_sys      = 1'b1;
    ext_rst_ni   = 1'b1;
    lock_i       = 1'b1;
    sw_rst_req_i = 1'b0;

    steps.push_back('{"run_idle",           5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00});
    steps.push_back('{"glitch3",            3,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00});
    steps.push_back('{"glitch_recover",     8,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00});
    steps.push_back('{"btn_hold10",         10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01});
    steps.push_back('{"btn_release_22",     22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01});
    steps.push_back('{"btn_reseq_periph",   1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01});
    steps.push_back('{"btn_reseq_30",       7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01});
    steps.push_back('{"btn_reseq_core",     1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01});
    steps.push_back('{"lock_drop_2",        2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01});
    steps.push_back('{"lock_drop_3",        1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10});
    steps.push_back('{"lock_stays_low",     40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10});
    steps.push_back('{"lock_back_18",       18, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10});
    steps.push_back('{"lock_back_periph",   1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10});
    steps.push_back('{"lock_back_26",       7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10});
    steps.push_back('{"lock_back_core",     1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10});
    steps.push_back('{"sw_pulse",           1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11});
    steps.push_back('{"sw_wait_17",         16, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11});
    steps.push_back('{"sw_periph_18",       1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11});
    steps.push_back('{"sw_wait_25",         7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11});
    steps.push_back('{"sw_core_26",         1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11});
    steps.push_back('{"simul_lock_2",       2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11});
    steps.push_back('{"simul_lock_sw",      1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10});
    steps.push_back('{"simul_recover_18",   18, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10});
    steps.push_back('{"simul_recover_19",   1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10});
    steps.push_back('{"simul_recover_core", 8,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10});

    for (int i = 0; i < 4; i++) tick();
    checkOutput("reset_state", 1'b0, 1'b0, 2'b00);

    powerOnSequence("poweron");

    foreach (steps[i]) begin
      applyStimulus(steps[i].ext, steps[i].lock, steps[i].sw, steps[i].cycles);
      checkOutput(steps[i].name, steps[i].exp_periph, steps[i].exp_core, steps[i].exp_cause);
    end

    // Reach PERIPH_UP through a software reset, then hit rst_sys between clock edges.
    applyStimulus(1'b1, 1'b1, 1'b1, 20);
    checkOutput("abort_in_periph_up", 1'b1, 1'b0, 2'b11);
    #2;
    rst_sys = 1'b1;
    #1;
    checkOutput("abort_async", 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("abort_held", 1'b0, 1'b0, 2'b00);

    powerOnSequence("reseq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
